// File: rtl/nios2_ocimem_pkg.sv
// Shared types and jdo field positions for the debug-monitor memory stage.
package nios2_ocimem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_J_RD  = 3'd1,
      ST_J_CAP = 3'd2,
      ST_J_WR  = 3'd3,
      ST_C_RD  = 3'd4,
      ST_C_ACK = 3'd5
   } ocimem_state_t;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_A    = 2'd1,
      CMD_B    = 2'd2,
      CMD_NA   = 2'd3
   } ocimem_cmd_t;

   localparam int JDO_RD_BIT   = 35;
   localparam int JDO_ADDR_LSB = 17;
   localparam int JDO_ADDR_MSB = 25;
   localparam int JDO_DATA_LSB = 3;
   localparam int JDO_DATA_MSB = 34;

endpackage

// File: rtl/nios2_ocimem_ram.sv
// Single-port 2^AW x 32 debug RAM, byte-writable, one-cycle read latency.
module nios2_ocimem_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   q
);

   logic [31:0] mem_r [0:(1<<AW)-1];

   // Byte-masked write and registered read (old data on a same-address write).
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) begin
            mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      q <= mem_r[addr];
   end

endmodule

// File: rtl/nios2_ocimem_monitor.sv
// Debug-monitor memory stage: serves JTAG monitor commands and CPU Avalon
// accesses to a shared on-chip debug RAM.
module nios2_ocimem_monitor
   import nios2_ocimem_pkg::*;
#(
   parameter int AW         = 8,
   parameter bit INIT_READY = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [37:0]   jdo,
   input  logic          take_action_ocimem_a,
   input  logic          take_action_ocimem_b,
   input  logic          take_no_action_ocimem_a,
   input  logic [AW-1:0] avs_address,
   input  logic          avs_read,
   input  logic          avs_write,
   input  logic [31:0]   avs_writedata,
   input  logic [3:0]    avs_byteenable,
   output logic [31:0]   avs_readdata,
   output logic          avs_waitrequest,
   output logic [31:0]   MonDReg,
   output logic [AW-1:0] MonAReg,
   output logic          monitor_ready,
   output logic          monitor_error
);

   ocimem_state_t state_r;
   ocimem_cmd_t   live_cmd_s, cmd_s, pend_kind_r;
   logic          pend_valid_r;
   logic [37:0]   pend_jdo_r, cmd_jdo_s;
   logic [31:0]   wr_data_r, avs_readdata_r, mon_dreg_r;
   logic [AW-1:0] mon_areg_r;
   logic          ready_r, error_r;
   logic [8:0]    cmd_addr_s;
   logic          addr_bad_s, cpu_wr_go_s;
   logic          ram_we_s;
   logic [3:0]    ram_be_s;
   logic [AW-1:0] ram_addr_s;
   logic [31:0]   ram_wdata_s, ram_q_s;
   logic          unused_s;

   // Decode the live strobes with a > b > no_action priority.
   always_comb begin
      live_cmd_s = CMD_NONE;
      if (take_action_ocimem_a) begin
         live_cmd_s = CMD_A;
      end else if (take_action_ocimem_b) begin
         live_cmd_s = CMD_B;
      end else if (take_no_action_ocimem_a) begin
         live_cmd_s = CMD_NA;
      end else begin
         live_cmd_s = CMD_NONE;
      end
   end

   // A held command always runs before a fresh one or any CPU request.
   always_comb begin
      cmd_s     = live_cmd_s;
      cmd_jdo_s = jdo;
      if (pend_valid_r) begin
         cmd_s     = pend_kind_r;
         cmd_jdo_s = pend_jdo_r;
      end else begin
         cmd_s     = live_cmd_s;
         cmd_jdo_s = jdo;
      end
   end

   assign cmd_addr_s  = cmd_jdo_s[JDO_ADDR_MSB:JDO_ADDR_LSB];
   assign addr_bad_s  = (cmd_addr_s >> AW) != 9'd0;
   assign cpu_wr_go_s = (state_r == ST_IDLE) && (cmd_s == CMD_NONE) && !avs_read
                        && avs_write && !reset;
   assign unused_s    = ^{cmd_jdo_s[37:36], cmd_jdo_s[2:0]};

   // RAM port steering per state.
   always_comb begin
      ram_we_s    = 1'b0;
      ram_be_s    = 4'h0;
      ram_addr_s  = mon_areg_r;
      ram_wdata_s = 32'h0;
      case (state_r)
         ST_IDLE: begin
            ram_we_s    = cpu_wr_go_s;
            ram_be_s    = avs_byteenable;
            ram_addr_s  = avs_address;
            ram_wdata_s = avs_writedata;
         end
         ST_J_WR: begin
            ram_we_s    = !reset;
            ram_be_s    = 4'hF;
            ram_addr_s  = mon_areg_r;
            ram_wdata_s = wr_data_r;
         end
         ST_C_RD: begin
            ram_addr_s = avs_address;
         end
         default: begin
            ram_addr_s = mon_areg_r;
         end
      endcase
   end

   nios2_ocimem_ram #(.AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .be    (ram_be_s),
      .addr  (ram_addr_s),
      .wdata (ram_wdata_s),
      .q     (ram_q_s)
   );

   // Monitor FSM, pending-strobe holder and registered monitor outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         pend_valid_r   <= 1'b0;
         pend_kind_r    <= CMD_NONE;
         pend_jdo_r     <= 38'h0;
         wr_data_r      <= 32'h0;
         avs_readdata_r <= 32'h0;
         mon_dreg_r     <= 32'h0;
         mon_areg_r     <= '0;
         ready_r        <= INIT_READY;
         error_r        <= 1'b0;
      end else begin
         if (live_cmd_s != CMD_NONE && (state_r != ST_IDLE || pend_valid_r)) begin
            pend_valid_r <= 1'b1;
            pend_kind_r  <= live_cmd_s;
            pend_jdo_r   <= jdo;
         end else if (state_r == ST_IDLE) begin
            pend_valid_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               case (cmd_s)
                  CMD_A: begin
                     mon_areg_r <= cmd_addr_s[AW-1:0];
                     if (addr_bad_s) begin
                        error_r <= 1'b1;
                        ready_r <= 1'b0;
                     end else begin
                        error_r <= 1'b0;
                        if (cmd_jdo_s[JDO_RD_BIT]) begin
                           ready_r <= 1'b0;
                           state_r <= ST_J_RD;
                        end
                     end
                  end
                  CMD_B: begin
                     wr_data_r <= cmd_jdo_s[JDO_DATA_MSB:JDO_DATA_LSB];
                     state_r   <= ST_J_WR;
                  end
                  CMD_NA: begin
                     mon_areg_r <= mon_areg_r + AW'(1);
                     ready_r    <= 1'b0;
                     state_r    <= ST_J_RD;
                  end
                  default: begin
                     if (avs_read) begin
                        state_r <= ST_C_RD;
                     end
                  end
               endcase
            end
            ST_J_RD:  state_r <= ST_J_CAP;
            ST_J_CAP: begin
               mon_dreg_r <= ram_q_s;
               ready_r    <= 1'b1;
               state_r    <= ST_IDLE;
            end
            ST_J_WR: begin
               mon_dreg_r <= wr_data_r;
               mon_areg_r <= mon_areg_r + AW'(1);
               state_r    <= ST_IDLE;
            end
            ST_C_RD:  state_r <= ST_C_ACK;
            ST_C_ACK: begin
               avs_readdata_r <= ram_q_s;
               state_r        <= ST_IDLE;
            end
            default:  state_r <= ST_IDLE;
         endcase
      end
   end

   // Read data is presented during the acknowledge cycle and held afterwards.
   assign avs_readdata    = (state_r == ST_C_ACK) ? ram_q_s : avs_readdata_r;
   assign avs_waitrequest = reset || !(cpu_wr_go_s || state_r == ST_C_ACK);
   assign MonDReg         = mon_dreg_r;
   assign MonAReg         = mon_areg_r;
   assign monitor_ready   = ready_r;
   assign monitor_error   = error_r;

endmodule

// File: tb/tb_nios2_ocimem_monitor.sv
// Directed self-checking bench for nios2_ocimem_monitor (AW = 8).
module tb_nios2_ocimem_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [7:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic [31:0] MonDReg;
   logic [7:0]  MonAReg;
   logic        monitor_ready, monitor_error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nios2_ocimem_monitor #(.AW(8), .INIT_READY(1'b0)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .avs_address             (avs_address),
      .avs_read                (avs_read),
      .avs_write               (avs_write),
      .avs_writedata           (avs_writedata),
      .avs_byteenable          (avs_byteenable),
      .avs_readdata            (avs_readdata),
      .avs_waitrequest         (avs_waitrequest),
      .MonDReg                 (MonDReg),
      .MonAReg                 (MonAReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [37:0] jdo_a(input logic rd, input logic [8:0] addr);
      logic [37:0] j;
      j = 38'h0;
      j[35] = rd;
      j[25:17] = addr;
      return j;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] data);
      logic [37:0] j;
      j = 38'h0;
      j[34:3] = data;
      return j;
   endfunction

   // Called at a negedge; returns at the following negedge with strobes low.
   task automatic pulse(input int kind, input logic [37:0] payload);
      jdo = payload;
      take_action_ocimem_a    = (kind == 0);
      take_action_ocimem_b    = (kind == 1);
      take_no_action_ocimem_a = (kind == 2);
      @(negedge clk);
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      int n;
      avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
      n = 0;
      #1;
      while (avs_waitrequest && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check("cpu_write_timeout", 32'(n < 20), 32'd1);
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] a, output logic [31:0] d);
      int n;
      avs_address = a; avs_read = 1'b1;
      n = 0;
      #1;
      while (avs_waitrequest && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check("cpu_read_timeout", 32'(n < 20), 32'd1);
      d = avs_readdata;
      @(negedge clk);
      avs_read = 1'b0;
      @(negedge clk);
   endtask

   logic [31:0] rd_data;

   initial begin
      reset = 1'b1; jdo = 38'h0;
      take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
      avs_address = 8'h0; avs_read = 1'b0; avs_write = 1'b0;
      avs_writedata = 32'h0; avs_byteenable = 4'h0;
      @(negedge clk); @(negedge clk);
      check("rst_dreg", MonDReg, 32'h0);
      check("rst_areg", 32'(MonAReg), 32'h0);
      check("rst_ready", 32'(monitor_ready), 32'h0);
      check("rst_error", 32'(monitor_error), 32'h0);
      check("rst_rdata", avs_readdata, 32'h0);
      check("rst_wait", 32'(avs_waitrequest), 32'h1);
      reset = 1'b0;
      @(negedge clk);

      // Known RAM contents.
      cpu_write(8'h05, 32'hA5A5_0005, 4'hF);
      cpu_write(8'h00, 32'h0000_0C0C, 4'hF);
      cpu_write(8'h03, 32'hAABB_CCDD, 4'hF);

      // JTAG read at 0x05 with 2-cycle latency.
      pulse(0, jdo_a(1'b1, 9'h005));
      @(negedge clk);
      check("t1_ready_early", 32'(monitor_ready), 32'h0);
      @(negedge clk);
      check("t1_ready", 32'(monitor_ready), 32'h1);
      check("t1_dreg", MonDReg, 32'hA5A5_0005);
      check("t1_areg", 32'(MonAReg), 32'h05);
      check("t1_error", 32'(monitor_error), 32'h0);

      // Address set, JTAG write, read back.
      pulse(0, jdo_a(1'b0, 9'h010));
      check("t2_areg_set", 32'(MonAReg), 32'h10);
      check("t2_ready_kept", 32'(monitor_ready), 32'h1);
      pulse(1, jdo_b(32'hDEAD_BEEF));
      @(negedge clk);
      check("t2_areg_inc", 32'(MonAReg), 32'h11);
      check("t2_dreg_wr", MonDReg, 32'hDEAD_BEEF);
      pulse(0, jdo_a(1'b1, 9'h010));
      @(negedge clk); @(negedge clk);
      check("t2_ready", 32'(monitor_ready), 32'h1);
      check("t2_dreg_rd", MonDReg, 32'hDEAD_BEEF);
      cpu_read(8'h10, rd_data);
      check("t2_cpu_rd", rd_data, 32'hDEAD_BEEF);

      // Auto-increment wraps 0xFF -> 0x00.
      pulse(0, jdo_a(1'b0, 9'h0FF));
      check("t3_areg_ff", 32'(MonAReg), 32'hFF);
      pulse(2, 38'h0);
      check("t3_ready_clr", 32'(monitor_ready), 32'h0);
      check("t3_areg_wrap", 32'(MonAReg), 32'h00);
      @(negedge clk); @(negedge clk);
      check("t3_ready", 32'(monitor_ready), 32'h1);
      check("t3_dreg", MonDReg, 32'h0000_0C0C);

      // Out-of-range address.
      pulse(0, jdo_a(1'b1, 9'h1FF));
      check("t4_error", 32'(monitor_error), 32'h1);
      check("t4_ready", 32'(monitor_ready), 32'h0);
      check("t4_areg", 32'(MonAReg), 32'hFF);
      @(negedge clk); @(negedge clk);
      check("t4_no_access", 32'(monitor_ready), 32'h0);
      pulse(0, jdo_a(1'b0, 9'h000));
      check("t4_error_clr", 32'(monitor_error), 32'h0);

      // CPU write collides with a JTAG read: JTAG first.
      jdo = jdo_a(1'b1, 9'h005);
      take_action_ocimem_a = 1'b1;
      avs_address = 8'h03; avs_writedata = 32'h1234_5678; avs_byteenable = 4'b0011;
      avs_write = 1'b1;
      #1;
      check("t5_wait_strobe", 32'(avs_waitrequest), 32'h1);
      @(negedge clk);
      take_action_ocimem_a = 1'b0;
      #1;
      check("t5_wait_jrd", 32'(avs_waitrequest), 32'h1);
      @(negedge clk); #1;
      check("t5_wait_jcap", 32'(avs_waitrequest), 32'h1);
      @(negedge clk); #1;
      check("t5_ready", 32'(monitor_ready), 32'h1);
      check("t5_dreg", MonDReg, 32'hA5A5_0005);
      check("t5_wait_go", 32'(avs_waitrequest), 32'h0);
      @(negedge clk);
      avs_write = 1'b0;
      cpu_read(8'h03, rd_data);
      check("t5_merge", rd_data, 32'hAABB_5678);

      // Reset while J_RD is active.
      pulse(0, jdo_a(1'b1, 9'h010));
      reset = 1'b1;
      @(negedge clk);
      check("t6_dreg", MonDReg, 32'h0);
      check("t6_areg", 32'(MonAReg), 32'h0);
      check("t6_ready", 32'(monitor_ready), 32'h0);
      check("t6_error", 32'(monitor_error), 32'h0);
      check("t6_rdata", avs_readdata, 32'h0);
      check("t6_wait", 32'(avs_waitrequest), 32'h1);
      reset = 1'b0;
      @(negedge clk);
      check("t6_no_cap", 32'(monitor_ready), 32'h0);
      cpu_read(8'h05, rd_data);
      check("t6_idle_rd", rd_data, 32'hA5A5_0005);

      // Strobe during a CPU read is held and run afterwards.
      avs_address = 8'h10; avs_read = 1'b1;
      @(negedge clk);
      pulse(0, jdo_a(1'b1, 9'h005));
      #1;
      check("t7_cpu_ack", 32'(avs_waitrequest), 32'h0);
      check("t7_cpu_data", avs_readdata, 32'hDEAD_BEEF);
      avs_read = 1'b0;
      begin
         int n;
         n = 0;
         while (!monitor_ready && n < 10) begin
            @(negedge clk); n++;
         end
         check("t7_pend_timeout", 32'(n < 10), 32'd1);
      end
      check("t7_dreg", MonDReg, 32'hA5A5_0005);
      check("t7_areg", 32'(MonAReg), 32'h05);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nios2_ocimem_monitor.md
Name: nios2_ocimem_monitor

Overview:
- Debug-monitor memory stage directly downstream of the CPU debug-slave wrapper.
- Consumes the system-clock-domain JTAG command strobes (`take_action_ocimem_a`, `take_action_ocimem_b`, `take_no_action_ocimem_a`) and the 38-bit `jdo` payload.
- Executes read/write accesses to a small on-chip debug RAM, which the CPU also reaches through an Avalon-MM slave port.
- Returns `MonDReg`, `monitor_ready` and `monitor_error`, which the wrapper shifts back out over JTAG.

Parameters:
- AW, 8, word-address width of the debug RAM (depth 2^AW words, 32-bit each); legal range 4..9.
- INIT_READY, 0, reset value of `monitor_ready`.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  JTAG payload, registered in the wrapper and stable while any strobe is high.
- take_action_ocimem_a  in  1  one-cycle strobe: set address and optionally start a read.
- take_action_ocimem_b  in  1  one-cycle strobe: write data to the current address.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read the next (auto-incremented) address.
- avs_address  in  AW  CPU word address.
- avs_read  in  1  CPU read request.
- avs_write  in  1  CPU write request.
- avs_writedata  in  32  CPU write data.
- avs_byteenable  in  4  CPU byte enables.
- avs_readdata  out  32  CPU read data.
- avs_waitrequest  out  1  CPU stall.
- MonDReg  out  32  monitor data register returned to JTAG.
- MonAReg  out  AW  current monitor word address.
- monitor_ready  out  1  `MonDReg` holds valid read data.
- monitor_error  out  1  last JTAG address was out of range.

Behaviour:
- Reset (synchronous, active-high) applies these values and forces the FSM to IDLE, aborting any access in flight (no RAM write commits in the reset cycle):
  - `MonDReg` = 0, `MonAReg` = 0
  - `monitor_ready` = INIT_READY, `monitor_error` = 0
  - `avs_readdata` = 0, `avs_waitrequest` = 1
- `jdo` fields:
  - `jdo[35]` = read flag.
  - `jdo[25:17]` = 9-bit address field.
  - `jdo[34:3]` = write data.
- FSM states: IDLE, J_RD, J_CAP, J_WR, C_RD, C_ACK.
- IDLE, JTAG command priority (strobes are mutually exclusive by construction; if more than one is seen, priority is a > b > no_action):
  - `take_action_ocimem_a`:
    - Load `MonAReg` ← `jdo[17+AW-1:17]`.
    - If `jdo[25:17+AW]` ≠ 0: set `monitor_error` = 1, clear `monitor_ready`, stay in IDLE, no access.
    - Else clear `monitor_error`. If `jdo[35]`, clear `monitor_ready` and go to J_RD; otherwise stay in IDLE.
  - `take_action_ocimem_b`: go to J_WR with data `jdo[34:3]`; `monitor_ready` is unchanged.
  - `take_no_action_ocimem_a`: `MonAReg` ← `MonAReg` + 1 (wraps 2^AW−1 → 0), clear `monitor_ready`, go to J_RD.
- IDLE, CPU access (only when no strobe is present that cycle):
  - `avs_read` → C_RD.
  - `avs_write` → single-cycle RAM write with byte enables; `avs_waitrequest` deasserts in that same cycle, then back to IDLE.
- Read timing:
  - J_RD: RAM address = `MonAReg`; 1-cycle synchronous RAM read; → J_CAP.
  - J_CAP: `MonDReg` ← RAM q, `monitor_ready` ← 1; → IDLE. Total latency is 2 cycles from strobe to `monitor_ready`.
  - J_WR: full-word RAM write at `MonAReg`; `MonDReg` ← write data; `MonAReg` ← `MonAReg` + 1 (wraps); → IDLE. The wrapper issues a separate a-strobe to reset the address if it needs to.
  - C_RD: RAM read issued; → C_ACK.
  - C_ACK: `avs_readdata` ← q, `avs_waitrequest` = 0 for exactly this cycle; → IDLE.
- `avs_waitrequest` is 1 in every state/cycle except the CPU-write completion cycle and C_ACK. A CPU request arriving while the FSM is busy stays stalled and is served on a later IDLE cycle.
- Simultaneous JTAG strobe and CPU request in IDLE: JTAG wins; the CPU stays stalled and is served on the next IDLE cycle in which no strobe is present.
- A JTAG strobe arriving in a non-IDLE state is held in a 1-deep pending register (with its `jdo` snapshot) and executed on return to IDLE, before any CPU request. A second strobe arriving while one is already pending overwrites it; the wrapper's protocol guarantees ≥4 cycles between strobes.
- RAM contents are not cleared by reset.

Decomposition:
- Shared package `nios2_ocimem_pkg`:
  - State enum `ocimem_state_t`.
  - `jdo` field constants: `JDO_RD_BIT` = 35, `JDO_ADDR_LSB` = 17, `JDO_ADDR_MSB` = 25, `JDO_DATA_LSB` = 3, `JDO_DATA_MSB` = 34.
- One sub-module `nios2_ocimem_ram`: single-port 2^AW×32 synchronous RAM with 4-bit byte enable and 1-cycle read latency, with no reset on data.

Test Plan:
- Reset, then pulse a with `jdo[35]` = 1 and address 0x05 → `monitor_ready` = 1 two cycles later; `MonDReg` = RAM[5]; `MonAReg` = 5; `monitor_error` = 0.
- Pulse a (address 0x10, read = 0), then pulse b with data 0xDEADBEEF, then a-read at 0x10 → `MonDReg` = 0xDEADBEEF; after the b-strobe `MonAReg` = 0x11.
- With `MonAReg` = 0xFF (AW = 8), pulse no_action → `MonAReg` = 0x00, `MonDReg` = RAM[0], `monitor_ready` = 1 after 2 cycles.
- Pulse a with address 0x1FF (AW = 8) → `monitor_error` = 1, `monitor_ready` = 0, `MonAReg` = 0xFF, no RAM access.
- Assert `avs_write` to address 3 (byteenable 0b0011, data 0x12345678) in the same cycle as an a-strobe → the JTAG read completes first, then the CPU write commits; a CPU read of address 3 returns the old upper bytes with 0x5678 in the low bytes.
- Assert reset during J_RD → next cycle all outputs are at reset values, `monitor_ready` is not set, and the FSM is in IDLE.
